// File: rtl/pipe_stage_buffer.sv
// ============================================================================
// Module      : pipe_stage_buffer
// Description : Elastic pipeline-stage register with a 2-entry skid store.
//               It carries opaque control and data bundles between two stages
//               over a valid/ready handshake. It supports flush (bubble
//               insertion) and zeroes the control bundle on every bubble.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_buffer #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 271
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The state value is the occupancy. The main entry is valid in ONE and
    // FULL, and the skid entry is valid only in FULL.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_main_valid;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    // in_ready depends only on registered state and reset. This keeps any
    // combinational path from out_ready or in_valid out of the handshake.
    assign w_main_valid = (r_state != ST_EMPTY);
    assign in_ready     = rst & (r_state != ST_FULL);
    assign w_in_fire    = in_valid & in_ready;
    assign w_out_fire   = w_main_valid & out_ready;

    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_valid ? r_main_ctrl : '0;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

    // Next-state and load-enable decode. Flush drops everything, including
    // a bundle presented in the same cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State and bundle storage. Reset clears everything and has priority.
    // Otherwise, payload registers change only when a load is enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
// ============================================================================
// Module      : tb_pipe_stage_buffer
// Description : Directed self-checking bench for pipe_stage_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_buffer;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 271;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle so that samples and new drives sit away
    // from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CTRL_W-1:0] c, input logic [31:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = '0;
        in_data[31:0] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        send(12'h555, 32'hDEAD_BEEF);
        repeat (3) step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_ctrl !== 12'h000) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 000", out_ctrl); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL release_occupancy: got %0d expected 0", occupancy); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(12'(i), 32'hD000_0000 + 32'(i));
            step();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 12'(i)) begin errors++; $display("FAIL stream_ctrl[%0d]: got v=%b ctrl=%h expected v=1 ctrl=%h", i, out_valid, out_ctrl, 12'(i)); end
            checks++; if (out_data[31:0] !== 32'hD000_0000 + 32'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data[31:0], 32'hD000_0000 + 32'(i)); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ[%0d]: got occ=%0d rdy=%b expected occ=1 rdy=1", i, occupancy, in_ready); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        send(12'h0A1, 32'h0000_00A1);
        step();
        checks++; if (out_ctrl !== 12'h0A1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_first: got ctrl=%h occ=%0d expected ctrl=0a1 occ=1", out_ctrl, occupancy); end
        out_ready = 1'b0;
        send(12'h0A2, 32'h0000_00A2);
        step();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, in_ready); end
        checks++; if (out_ctrl !== 12'h0A1 || out_data[31:0] !== 32'hA1) begin errors++; $display("FAIL bp_stable1: got ctrl=%h data=%h expected 0a1/a1", out_ctrl, out_data[31:0]); end
        send(12'h0A3, 32'h0000_00A3);
        step();
        checks++; if (occupancy !== 2'd2 || out_ctrl !== 12'h0A1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got occ=%0d ctrl=%h v=%b expected occ=2 ctrl=0a1 v=1", occupancy, out_ctrl, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (out_ctrl !== 12'h0A2 || out_data[31:0] !== 32'hA2 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_second: got ctrl=%h data=%h occ=%0d expected 0a2/a2/1", out_ctrl, out_data[31:0], occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
        step();
        checks++; if (out_ctrl !== 12'h0A3 || out_data[31:0] !== 32'hA3 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_third: got ctrl=%h data=%h occ=%0d expected 0a3/a3/1", out_ctrl, out_data[31:0], occupancy); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_drain: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        send(12'h0B1, 32'h0000_00B1);
        step();
        send(12'h0B2, 32'h0000_00B2);
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: got occ=%0d expected 2", occupancy); end
        send(12'h0FF, 32'h0000_00FF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_full: got v=%b ctrl=%h occ=%0d expected v=0 ctrl=000 occ=0", out_valid, out_ctrl, occupancy); end
        checks++; if (out_data[31:0] !== 32'hB1) begin errors++; $display("FAIL flush_data_kept: got %h expected b1", out_data[31:0]); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || out_ctrl === 12'h0FF) begin errors++; $display("FAIL flush_no_leak[%0d]: got v=%b ctrl=%h expected v=0 ctrl=000", i, out_valid, out_ctrl); end
        end
        // Flush that coincides with out_fire still leaves the block empty.
        send(12'h0C1, 32'h0000_00C1);
        step();
        flush = 1'b1;
        send(12'h0C2, 32'h0000_00C2);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_outfire: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        send(12'hFFF, 32'h0000_1234);
        step();
        checks++; if (out_ctrl !== 12'hFFF || out_valid !== 1'b1) begin errors++; $display("FAIL bubble_pre: got ctrl=%h v=%b expected fff/1", out_ctrl, out_valid); end
        in_valid = 1'b0;
        step();
        checks++; if (out_ctrl !== 12'h000 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble_ctrl: got ctrl=%h v=%b expected 000/0", out_ctrl, out_valid); end
        checks++; if (out_data[31:0] !== 32'h1234) begin errors++; $display("FAIL bubble_data: got %h expected 1234", out_data[31:0]); end
    endtask

    task automatic test_reset_priority();
        out_ready = 1'b0;
        send(12'h0D1, 32'h0000_00D1);
        step();
        send(12'h0D2, 32'h0000_00D2);
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstpri_fill: got occ=%0d expected 2", occupancy); end
        rst = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        send(12'h0D3, 32'h0000_00D3);
        step();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || occupancy !== 2'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstpri_state: got v=%b ctrl=%h occ=%0d rdy=%b expected 0/000/0/0", out_valid, out_ctrl, occupancy, in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstpri_data: got %h expected 0", out_data); end
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstpri_release: got occ=%0d rdy=%b v=%b expected 0/1/0", occupancy, in_ready, out_valid); end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_bubble();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised elastic pipeline-stage register, the successor to the fixed ID/EX buffer. It carries a control bundle and a data bundle between any two pipeline stages using a valid/ready handshake and a 2-entry skid store. It also supports flush (bubble insertion) and forces the control bundle to zero on every bubble. Instances sit at IF/ID, ID/EX, EX/MEM and MEM/WB; widths are set per stage.

## Interface
- CTRL_W, default 12: control-bundle width. ID/EX packing is ALUSrc, branch, memWrite, memRead, memToReg, regWrite, ALUOp[1:0], instructionALUCtr[3:0].
- DATA_W, default 271: data-bundle width. ID/EX packing is pc, data1, data2, immGen (4×64) plus writeReg, readReg1, readReg2 (3×5).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream holds a valid bundle.
- in_ready  out  1  block can accept; function of registered state and rst only.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- flush  in  1  discard all held and incoming bundles (branch mispredict / hazard squash).
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  output control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  output data bundle.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Storage:
  - main entry (valid, ctrl, data), which drives the outputs;
  - skid entry (valid, ctrl, data).
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- in_ready = rst & ~skid_valid.
- out_valid = main_valid.
- out_ctrl = main_valid ? main_ctrl : 0.
- out_data = main_data. It holds its last value on a bubble and is not cleared.
- States are encoded by occupancy:
  - EMPTY (0): in_fire → ONE, main ← in.
  - ONE (1):
    - in_fire & out_fire → ONE, main ← in.
    - in_fire & ~out_fire → FULL, skid ← in.
    - ~in_fire & out_fire → EMPTY.
    - otherwise hold.
  - FULL (2): in_ready=0. out_fire → ONE, main ← skid, skid_valid ← 0. Otherwise hold.
- Ordering is strictly FIFO. Main always holds the older entry.
- Flush (rst high): next state is EMPTY. main_valid and skid_valid are cleared, and any bundle presented the same cycle is dropped. main_data and skid contents are not cleared.
- Reset (rst low at posedge): all valids, ctrl and data registers are cleared to 0. Reset has priority over flush and over both handshakes.
- Bundles are opaque. No field is interpreted, so there is no width arithmetic.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=0 while rst=0 and 1 on the first cycle after release.
- Latency: a bundle accepted at edge k appears on the outputs after edge k, i.e. 1 cycle.
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- There is no combinational path from out_ready or in_valid to in_ready, or from in_* to out_*.
- When out_ready drops, at most one further bundle is absorbed (into skid). in_ready deasserts the following cycle.
- Under backpressure, out_valid, out_ctrl and out_data are stable until out_fire.
- If flush coincides with out_fire, the downstream has consumed the main entry. The block still empties.
- Reset mid-operation: the block is EMPTY after the reset edge, regardless of prior occupancy.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. After release, in_ready=1.
- Streaming: send ctrl=0x001..0x00A back-to-back with out_ready=1 → each appears 1 cycle later in order, occupancy stays 1, and there are no gaps.
- Backpressure/skid: stream 0x0A1, 0x0A2, 0x0A3, drop out_ready after 0x0A1 is presented.
  - 0x0A2 is absorbed and occupancy=2; in_ready=0 next cycle.
  - 0x0A3 is held upstream.
  - Restore out_ready → output sequence is 0x0A1, 0x0A2, 0x0A3, none lost or duplicated.
- Flush in FULL: with occupancy=2 and in_valid=1 (ctrl 0x0FF), assert flush for 1 cycle → next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0x0FF never appears at the output.
- Bubble control zeroing: leave in_valid=0 after a bundle with ctrl=0xFFF and data=0x1234 drains → out_ctrl=0 and out_data stays 0x1234.
- Reset priority: assert rst=0 and flush=1 together at occupancy=2 → all outputs are at their reset values, including out_data=0.
